// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - handshaked WIDTH-bit ALU with iterative shift-add multiply
// Holds one op in flight; single-cycle ops can issue back-to-back while the previous result retires.
module ula_multiciclo #(
    parameter int WIDTH      = 32,
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       controle,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry,
    output logic             negative,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               cy_q, cy_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH:0]     add_sum, sub_sum;
    logic               add_ovf, sub_ovf;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf, alu_cy;
    logic [2*WIDTH-1:0] acc_step;
    logic               is_mul;

    // Subtraction is a + ~b + 1 so its carry-out is the no-borrow flag.
    always_comb begin
        add_sum = {1'b0, a} + {1'b0, b};
        sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] == b[WIDTH-1]);
    end

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_cy  = 1'b0;
        case (controle)
            3'b000: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_ovf = add_ovf;
                alu_cy  = add_sum[WIDTH];
            end
            3'b001: begin
                alu_res = sub_sum[WIDTH-1:0];
                alu_ovf = sub_ovf;
                alu_cy  = sub_sum[WIDTH];
            end
            3'b010: alu_res = a & b;
            3'b011: alu_res = a | b;
            3'b100: alu_res = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH-1] ^ sub_ovf};
            3'b101: alu_res = a ^ b;
            3'b110: alu_res = '0;
            default: alu_res = ~(a | b);
        endcase
    end

    assign is_mul   = ENABLE_MUL && (controle == 3'b110);
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        cy_d      = cy_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_MUL: begin
                busy     = 1'b1;
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    result_d = acc_step[WIDTH-1:0];
                    ovf_d    = |acc_step[2*WIDTH-1:WIDTH];
                    cy_d     = 1'b0;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (in_valid && in_ready) begin
            if (is_mul) begin
                state_d  = S_MUL;
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, a};
                mplier_d = b;
                cnt_d    = '0;
            end else begin
                state_d  = S_DONE;
                result_d = alu_res;
                ovf_d    = alu_ovf;
                cy_d     = alu_cy;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            ovf_q    <= 1'b0;
            cy_q     <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            cy_q     <= cy_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result   = result_q;
    assign zero     = (result_q == '0);
    assign negative = result_q[WIDTH-1];
    assign overflow = ovf_q;
    assign carry    = cy_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb/tb_ula_multiciclo.sv - scoreboard bench for ula_multiciclo
module tb_ula_multiciclo;
    localparam int W = 32;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W - 1));

    logic         clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, zero, overflow, carry, negative, busy;
    logic [W-1:0] a = '0, b = '0, result;
    logic [2:0]   controle = '0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         ov;
        logic         c;
        logic         n;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0, checks = 0;
    int   rdy_mode = 0;
    int   lat, nbusy;

    ula_multiciclo #(.WIDTH(W), .ENABLE_MUL(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .controle(controle), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow), .carry(carry),
        .negative(negative), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t            e;
        longint          sx, sy, s;
        longint unsigned ux, uy, r;
        e  = '0;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        case (op)
            3'd0: begin
                r = ux + uy; s = sx + sy;
                e.res = r[W-1:0]; e.c = r[W]; e.ov = (s > SMAX) || (s < SMIN);
            end
            3'd1: begin
                r = ux - uy; s = sx - sy;
                e.res = r[W-1:0]; e.c = (ux >= uy); e.ov = (s > SMAX) || (s < SMIN);
            end
            3'd2: e.res = x & y;
            3'd3: e.res = x | y;
            3'd4: e.res = (sx < sy) ? W'(1) : W'(0);
            3'd5: e.res = x ^ y;
            3'd6: begin
                r = ux * uy;
                e.res = r[W-1:0]; e.ov = (r >> W) != 0;
            end
            default: e.res = ~(x | y);
        endcase
        e.z = (e.res == '0);
        e.n = e.res[W-1];
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corner [5];
        corner = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        if ($urandom_range(3) == 0) return corner[$urandom_range(4)];
        return $urandom;
    endfunction

    // Entered at a falling edge; returns at the falling edge after the accept.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n = 0;
        in_valid = 1'b1; controle = op; a = x; b = y;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) begin
            miscompares++;
            $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end else begin
            sb.push_back(model(op, x, y));
            vectors++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts cycles (and busy cycles) from the cycle after accept until out_valid.
    task automatic wait_out(output int n, output int nb);
        n = 1; nb = 0;
        #1;
        while (!out_valid && n < 100) begin
            if (busy) nb++;
            @(negedge clk); #1; n++;
        end
        if (!out_valid) begin
            miscompares++;
            $display("FAIL wait_out_timeout: out_valid=0 after %0d cycles, required 1", n);
        end
    endtask

    // Monitor: drives out_ready, retires results against the scoreboard, checks hold stability.
    initial begin : monitor
        exp_t got, hv, e;
        logic held;
        held = 1'b0;
        hv   = '0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(3) != 0);
                default: out_ready = 1'b0;
            endcase
            #2;
            got = {result, zero, overflow, carry, negative};
            if (held) chk("hold_stable", got, hv);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output: out_valid=1 result=%0h, required no output", result);
                end else begin
                    e = sb.pop_front();
                    chk("retire", got, e);
                end
            end
            held = out_valid && !out_ready && !reset;
            hv   = got;
        end
    end

    initial begin : main
        int cyc;
        logic [2:0] op;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result_flags", {result, zero, overflow, carry, negative}, {32'h0, 4'b1000});
        @(negedge clk);

        issue(3'd0, 32'h7FFFFFFF, 32'h1);
        wait_out(lat, nbusy);
        chk("add_latency", lat, 1);
        chk("add_ovf_flags", {result, overflow, negative, carry}, {32'h80000000, 3'b110});
        @(negedge clk);

        issue(3'd1, 32'h5, 32'h5);
        wait_out(lat, nbusy);
        chk("sub_zero_carry", {result, zero, carry}, {32'h0, 2'b11});
        @(negedge clk);

        issue(3'd4, 32'hFFFFFFFF, 32'h1);
        wait_out(lat, nbusy);
        chk("slt_result", {result, overflow, carry}, {32'h1, 2'b00});
        @(negedge clk);

        issue(3'd6, 32'h0000FFFF, 32'h0000FFFF);
        wait_out(lat, nbusy);
        chk("mul_latency", lat, W + 1);
        chk("mul_busy_cycles", nbusy, W);
        chk("mul_result", {result, overflow}, {32'hFFFE0001, 1'b0});
        @(negedge clk);

        issue(3'd6, 32'h00010000, 32'h00010000);
        wait_out(lat, nbusy);
        chk("mul_high_ovf", {result, zero, overflow}, {32'h0, 2'b11});
        rdy_mode = 2;
        @(negedge clk);

        issue(3'd0, 32'h12345678, 32'h0F0F0F0F);
        wait_out(lat, nbusy);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
        end
        rdy_mode = 0;
        @(negedge clk);
        issue(3'd2, 32'hF0F0_1234, 32'hFF00_FF00);
        issue(3'd3, 32'h0000_1111, 32'h8000_0000);
        issue(3'd5, 32'hAAAA_5555, 32'hFFFF_0000);
        #1;
        chk("stream_out_valid", out_valid, 1);
        #2;
        chk("stream_one_per_cycle", sb.size(), 0);
        @(negedge clk);

        issue(3'd6, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; controle = 3'd0;
        sb.delete();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("midmul_rst_out_valid", out_valid, 0);
        chk("midmul_rst_busy", busy, 0);
        chk("midmul_rst_in_ready", in_ready, 1);
        chk("midmul_rst_result", {result, zero}, {32'h0, 1'b1});
        repeat (40) @(negedge clk);
        #1;
        rdy_mode = 1;
        @(negedge clk);

        cyc = 0;
        while (vectors < 10000 && cyc < 90000) begin
            op = 3'($urandom_range(7));
            if (op == 3'd6 && $urandom_range(1) == 0) op = 3'($urandom_range(5));
            in_valid = ($urandom_range(3) != 0);
            controle = op;
            a = pick();
            b = pick();
            #1;
            if (in_valid && in_ready) begin
                sb.push_back(model(op, a, b));
                vectors++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (vectors < 10000) begin
            miscompares++;
            $display("FAIL random_budget: %0d vectors accepted, required 10000", vectors);
        end
        cyc = 0;
        while (sb.size() != 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        #3;
        chk("drain_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
